// File: rtl/display_pkg.sv
// Shared types and constants for the display layer controller:
// colour format, palette reset contents and config register map.
package display_pkg;

    localparam int COLOR_W     = 12;
    localparam int PAL_ENTRIES = 4;

    typedef logic [COLOR_W-1:0]                   color_t;
    typedef logic [PAL_ENTRIES-1:0][COLOR_W-1:0]  palette_t;

    // An icon pixel of this value lets lower layers show through.
    localparam color_t TRANSPARENT = 12'h000;

    // Power-up palette: white, black, brown, red.
    localparam color_t PAL_RST_0 = 12'hFFF;
    localparam color_t PAL_RST_1 = 12'h000;
    localparam color_t PAL_RST_2 = 12'h840;
    localparam color_t PAL_RST_3 = 12'hF00;

    // Config register map; addresses 5..7 are reserved and ignored.
    localparam logic [2:0] CFG_ADDR_PAL0  = 3'd0;
    localparam logic [2:0] CFG_ADDR_PAL1  = 3'd1;
    localparam logic [2:0] CFG_ADDR_PAL2  = 3'd2;
    localparam logic [2:0] CFG_ADDR_PAL3  = 3'd3;
    localparam logic [2:0] CFG_ADDR_BLINK = 3'd4;

    // Reset colour for a given world-map code.
    function automatic color_t pal_reset_value(input logic [1:0] code);
        color_t val;
        case (code)
            2'd0:    val = PAL_RST_0;
            2'd1:    val = PAL_RST_1;
            2'd2:    val = PAL_RST_2;
            default: val = PAL_RST_3;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/display_cfg_regs.sv
// Double-buffered palette / blink-mask registers. Writes land in the shadow
// copy; a commit request is held pending and copied into the active copy at
// the next frame boundary. Also owns the per-frame blink counter.
module display_cfg_regs
    import display_pkg::*;
#(
    parameter int NUM_ICONS    = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_addr,
    input  logic [COLOR_W-1:0]   cfg_wdata,
    input  logic                 cfg_commit,
    input  logic                 boundary,
    output palette_t             pal_active,
    output logic [NUM_ICONS-1:0] mask_active,
    output logic                 cfg_pending,
    output logic                 blink_phase
);

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    color_t               pal_shadow_reg [PAL_ENTRIES];
    color_t               pal_active_reg [PAL_ENTRIES];
    logic [NUM_ICONS-1:0] mask_shadow_reg;
    logic [NUM_ICONS-1:0] mask_active_reg;
    logic                 pending_reg;
    logic                 phase_reg;
    logic [7:0]           frame_cnt_reg;
    logic                 load;

    // The active copy only moves at a boundary with a commit outstanding; the
    // shadow value used is the one held before this edge, so a write in the
    // same cycle as the load waits for the next commit.
    assign load = boundary && pending_reg;

    genvar gi;
    generate
        for (gi = 0; gi < PAL_ENTRIES; gi++) begin : g_pal
            // Palette entry gi: shadow takes writes, active takes the shadow on load.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pal_shadow_reg[gi] <= pal_reset_value(2'(gi));
                    pal_active_reg[gi] <= pal_reset_value(2'(gi));
                end else begin
                    if (cfg_we && (cfg_addr == (CFG_ADDR_PAL0 + 3'(gi)))) begin
                        pal_shadow_reg[gi] <= cfg_wdata;
                    end
                    if (load) begin
                        pal_active_reg[gi] <= pal_shadow_reg[gi];
                    end
                end
            end

            assign pal_active[gi] = pal_active_reg[gi];
        end
    endgenerate

    // Blink mask shadow/active pair, same update rules as the palette.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_shadow_reg <= '0;
            mask_active_reg <= '0;
        end else begin
            if (cfg_we && (cfg_addr == CFG_ADDR_BLINK)) begin
                mask_shadow_reg <= cfg_wdata[NUM_ICONS-1:0];
            end
            if (load) begin
                mask_active_reg <= mask_shadow_reg;
            end
        end
    end

    // Commit tracking: a commit always (re)arms pending, so one arriving on the
    // boundary cycle survives that boundary and is applied at the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg <= 1'b0;
        end else if (cfg_commit) begin
            pending_reg <= 1'b1;
        end else if (boundary) begin
            pending_reg <= 1'b0;
        end
    end

    // Frame counter: wraps after BLINK_FRAMES boundaries and flips the phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_reg <= 8'd0;
            phase_reg     <= 1'b0;
        end else if (boundary) begin
            if (frame_cnt_reg == BLINK_LAST) begin
                frame_cnt_reg <= 8'd0;
                phase_reg     <= ~phase_reg;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
        end
    end

    assign mask_active = mask_active_reg;
    assign cfg_pending = pending_reg;
    assign blink_phase = phase_reg;

endmodule

// File: rtl/display_layer_ctrl.sv
// Pixel-path controller: two-stage pipeline that picks the highest-priority
// visible icon or the palette-mapped world-map colour, with syncs delayed to
// stay aligned with the RGB output.
module display_layer_ctrl
    import display_pkg::*;
#(
    parameter int   NUM_ICONS    = 2,
    parameter int   BLINK_FRAMES = 30,
    parameter logic SYNC_ACTIVE  = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [COLOR_W*NUM_ICONS-1:0] icon_pix,
    input  logic [1:0]                   world_pixel,
    input  logic                         video_on,
    input  logic                         hsync_in,
    input  logic                         vsync_in,
    input  logic                         cfg_we,
    input  logic [2:0]                   cfg_addr,
    input  logic [COLOR_W-1:0]           cfg_wdata,
    input  logic                         cfg_commit,
    output logic                         cfg_pending,
    output logic                         blink_phase,
    output logic [3:0]                   VGA_R,
    output logic [3:0]                   VGA_G,
    output logic [3:0]                   VGA_B,
    output logic                         hsync_out,
    output logic                         vsync_out
);

    // Stage 1
    logic [COLOR_W*NUM_ICONS-1:0] icon_s1_reg;
    logic [1:0]                   world_s1_reg;
    logic                         video_s1_reg;
    logic                         hsync_s1_reg;
    logic                         vsync_s1_reg;

    // Stage 2
    color_t                       rgb_reg;
    logic                         hsync_s2_reg;
    logic                         vsync_s2_reg;

    logic                         boundary;
    palette_t                     pal_active;
    logic [NUM_ICONS-1:0]         mask_active;
    logic [NUM_ICONS-1:0]         icon_show;
    color_t                       color_next;

    // Stage-2 vsync holds the previous stage-1 value, so comparing the two
    // gives a one-cycle pulse on the inactive-to-active edge.
    assign boundary = (vsync_s1_reg == SYNC_ACTIVE) && (vsync_s2_reg != SYNC_ACTIVE);

    display_cfg_regs #(
        .NUM_ICONS    (NUM_ICONS),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_cfg (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .boundary    (boundary),
        .pal_active  (pal_active),
        .mask_active (mask_active),
        .cfg_pending (cfg_pending),
        .blink_phase (blink_phase)
    );

    // Stage 1: capture pixel inputs. Syncs reset to their inactive level so
    // leaving reset can never look like a frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            icon_s1_reg  <= '0;
            world_s1_reg <= 2'd0;
            video_s1_reg <= 1'b0;
            hsync_s1_reg <= ~SYNC_ACTIVE;
            vsync_s1_reg <= ~SYNC_ACTIVE;
        end else begin
            icon_s1_reg  <= icon_pix;
            world_s1_reg <= world_pixel;
            video_s1_reg <= video_on;
            hsync_s1_reg <= hsync_in;
            vsync_s1_reg <= vsync_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ICONS; gi++) begin : g_icon
            assign icon_show[gi] =
                (icon_s1_reg[gi*COLOR_W +: COLOR_W] != TRANSPARENT) &&
                !(blink_phase && mask_active[gi]);
        end
    endgenerate

    // Priority mux: scanning from the lowest priority up lets icon 0 win last.
    always_comb begin
        color_next = pal_active[world_s1_reg];
        for (int i = NUM_ICONS - 1; i >= 0; i--) begin
            if (icon_show[i]) begin
                color_next = icon_s1_reg[i*COLOR_W +: COLOR_W];
            end
        end
        if (!video_s1_reg) begin
            color_next = TRANSPARENT;
        end
    end

    // Stage 2: registered colour and syncs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_reg      <= TRANSPARENT;
            hsync_s2_reg <= ~SYNC_ACTIVE;
            vsync_s2_reg <= ~SYNC_ACTIVE;
        end else begin
            rgb_reg      <= color_next;
            hsync_s2_reg <= hsync_s1_reg;
            vsync_s2_reg <= vsync_s1_reg;
        end
    end

    assign VGA_R     = rgb_reg[11:8];
    assign VGA_G     = rgb_reg[7:4];
    assign VGA_B     = rgb_reg[3:0];
    assign hsync_out = hsync_s2_reg;
    assign vsync_out = vsync_s2_reg;

endmodule

// File: tb/tb_display_layer_ctrl.sv
// Scoreboard bench for display_layer_ctrl: stimulus pushes expected pixel and
// status values tagged with the cycle they are due; a monitor compares them.
module tb_display_layer_ctrl;

    localparam int   NI = 2;
    localparam int   BF = 2;
    localparam logic SA = 1'b0;

    logic             clk = 1'b0;
    logic             reset;
    logic [12*NI-1:0] icon_pix;
    logic [1:0]       world_pixel;
    logic             video_on;
    logic             hsync_in;
    logic             vsync_in;
    logic             cfg_we;
    logic [2:0]       cfg_addr;
    logic [11:0]      cfg_wdata;
    logic             cfg_commit;
    logic             cfg_pending;
    logic             blink_phase;
    logic [3:0]       VGA_R;
    logic [3:0]       VGA_G;
    logic [3:0]       VGA_B;
    logic             hsync_out;
    logic             vsync_out;

    always #5 clk = ~clk;

    display_layer_ctrl #(
        .NUM_ICONS    (NI),
        .BLINK_FRAMES (BF),
        .SYNC_ACTIVE  (SA)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .icon_pix    (icon_pix),
        .world_pixel (world_pixel),
        .video_on    (video_on),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .cfg_pending (cfg_pending),
        .blink_phase (blink_phase),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
    );

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        string       nm;
    } pix_exp_t;

    typedef struct {
        int    due;
        logic  pend;
        logic  ph;
        string nm;
    } st_exp_t;

    pix_exp_t pix_q[$];
    st_exp_t  st_q[$];
    int       cyc   = 0;
    int       total = 0;
    int       bad   = 0;
    logic [7:0] hs_cnt = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one cycle after each rising edge, compare everything due now.
    initial begin : monitor
        pix_exp_t pe;
        st_exp_t  se;
        logic [11:0] got;
        forever begin
            @(posedge clk);
            #1;
            got = {VGA_R, VGA_G, VGA_B};
            while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
                pe = pix_q.pop_front();
                total++;
                if (pe.due != cyc) begin
                    bad++;
                    $display("FAIL %s: stale entry due=%0d now=%0d", pe.nm, pe.due, cyc);
                end else begin
                    if (got !== pe.rgb) begin
                        bad++;
                        $display("FAIL %s: rgb got=%h want=%h", pe.nm, got, pe.rgb);
                    end else begin
                        $display("ok   %s: rgb=%h", pe.nm, got);
                    end
                    total++;
                    if (hsync_out !== pe.hs || vsync_out !== pe.vs) begin
                        bad++;
                        $display("FAIL %s_sync: hs/vs got=%b%b want=%b%b",
                                 pe.nm, hsync_out, vsync_out, pe.hs, pe.vs);
                    end
                end
            end
            while (st_q.size() > 0 && st_q[0].due <= cyc) begin
                se = st_q.pop_front();
                total++;
                if (se.due != cyc || cfg_pending !== se.pend || blink_phase !== se.ph) begin
                    bad++;
                    $display("FAIL %s: pend/phase got=%b/%b want=%b/%b (due=%0d now=%0d)",
                             se.nm, cfg_pending, blink_phase, se.pend, se.ph, se.due, cyc);
                end else begin
                    $display("ok   %s: pend=%b phase=%b", se.nm, cfg_pending, blink_phase);
                end
            end
        end
    end

    // Drive one pixel cycle and record its output two edges later.
    task automatic step(input logic [11:0] i0, input logic [11:0] i1, input logic [1:0] w,
                        input logic v, input logic vs, input logic we, input logic [2:0] a,
                        input logic [11:0] d, input logic cm, input logic [11:0] exp_rgb,
                        input string nm);
        @(negedge clk);
        icon_pix    = {i1, i0};
        world_pixel = w;
        video_on    = v;
        hsync_in    = hs_cnt[1];
        vsync_in    = vs;
        cfg_we      = we;
        cfg_addr    = a;
        cfg_wdata   = d;
        cfg_commit  = cm;
        hs_cnt      = hs_cnt + 8'd1;
        pix_q.push_back('{cyc + 2, exp_rgb, hsync_in, vs, nm});
    endtask

    task automatic expect_state(input int dly, input logic pend, input logic ph, input string nm);
        st_q.push_back('{cyc + dly, pend, ph, nm});
    endtask

    task automatic pix(input logic [11:0] i0, input logic [11:0] i1, input logic [1:0] w,
                       input logic v, input logic [11:0] exp_rgb, input string nm);
        step(i0, i1, w, v, 1'b1, 1'b0, 3'd0, 12'h000, 1'b0, exp_rgb, nm);
    endtask

    task automatic wr(input logic [2:0] a, input logic [11:0] d, input logic [11:0] exp_w0,
                      input string nm);
        step(12'h000, 12'h000, 2'd0, 1'b1, 1'b1, 1'b1, a, d, 1'b0, exp_w0, nm);
    endtask

    task automatic cmt(input logic [11:0] exp_w0, input logic ph, input string nm);
        step(12'h000, 12'h000, 2'd0, 1'b1, 1'b1, 1'b0, 3'd0, 12'h000, 1'b1, exp_w0, nm);
        expect_state(1, 1'b1, ph, {nm, "_pend"});
    endtask

    // Frame boundary: vsync goes active for two pixels. The first pixel is
    // computed with the old registers, the second with the newly loaded ones.
    task automatic bnd(input logic [11:0] i0, input logic [11:0] i1, input logic [1:0] w,
                       input logic [11:0] exp_old, input logic [11:0] exp_new,
                       input logic pb, input logic pa, input logic phb, input logic pha,
                       input logic we2, input logic [2:0] a2, input logic [11:0] d2,
                       input logic cm2, input string nm);
        step(i0, i1, w, 1'b1, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0, exp_old, {nm, "_old"});
        expect_state(1, pb, phb, {nm, "_st_before"});
        expect_state(2, pa, pha, {nm, "_st_after"});
        step(i0, i1, w, 1'b1, 1'b0, we2, a2, d2, cm2, exp_new, {nm, "_new"});
        step(i0, i1, w, 1'b1, 1'b1, 1'b0, 3'd0, 12'h000, 1'b0, exp_new, {nm, "_new2"});
        step(i0, i1, w, 1'b1, 1'b1, 1'b0, 3'd0, 12'h000, 1'b0, exp_new, {nm, "_new3"});
    endtask

    // Reset with every other input busy, to show reset wins.
    task automatic do_reset(input string nm);
        repeat (2) @(negedge clk);
        reset       = 1'b1;
        icon_pix    = {12'h000, 12'hABC};
        world_pixel = 2'd0;
        video_on    = 1'b1;
        hsync_in    = 1'b0;
        vsync_in    = 1'b0;
        cfg_we      = 1'b1;
        cfg_addr    = 3'd0;
        cfg_wdata   = 12'h123;
        cfg_commit  = 1'b1;
        pix_q.push_back('{cyc + 1, 12'h000, 1'b1, 1'b1, {nm, "_out"}});
        expect_state(1, 1'b0, 1'b0, {nm, "_state"});
        repeat (2) @(negedge clk);
        reset       = 1'b0;
        icon_pix    = '0;
        video_on    = 1'b0;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        cfg_we      = 1'b0;
        cfg_commit  = 1'b0;
        expect_state(1, 1'b0, 1'b0, {nm, "_release"});
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; icon_pix = '0; world_pixel = 2'd0; video_on = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0;
        cfg_wdata = 12'h000; cfg_commit = 1'b0;

        do_reset("reset0");

        // Layer selection with reset palette
        pix(12'h000, 12'h000, 2'd2, 1'b1, 12'h840, "world2");
        pix(12'h0F0, 12'h00F, 2'd0, 1'b1, 12'h0F0, "icon0_wins");
        pix(12'h000, 12'h00F, 2'd0, 1'b1, 12'h00F, "icon1_only");
        pix(12'h0F0, 12'h00F, 2'd3, 1'b0, 12'h000, "video_off");
        pix(12'h000, 12'h000, 2'd3, 1'b1, 12'hF00, "world3");
        pix(12'h000, 12'h000, 2'd1, 1'b1, 12'h000, "world1");
        pix(12'h000, 12'h000, 2'd0, 1'b1, 12'hFFF, "world0");
        pix(12'h0F0, 12'h000, 2'd0, 1'b1, 12'h0F0, "icon0_only");

        // Shadow write and mid-frame commit
        wr(3'd0, 12'h123, 12'hFFF, "wr_pal0");
        wr(3'd5, 12'hABC, 12'hFFF, "wr_reserved");
        cmt(12'hFFF, 1'b0, "commit1");
        repeat (3) pix(12'h000, 12'h000, 2'd0, 1'b1, 12'hFFF, "pre_b1");
        // B1: load 123; write of 456 on the load cycle stays in shadow
        bnd(12'h000, 12'h000, 2'd0, 12'hFFF, 12'h123, 1'b1, 1'b0, 1'b0, 1'b0,
            1'b1, 3'd0, 12'h456, 1'b0, "b1");
        repeat (2) pix(12'h000, 12'h000, 2'd0, 1'b1, 12'h123, "after_b1");

        // B2: commit on the boundary cycle is deferred
        bnd(12'h000, 12'h000, 2'd0, 12'h123, 12'h123, 1'b0, 1'b1, 1'b0, 1'b1,
            1'b0, 3'd0, 12'h000, 1'b1, "b2");
        repeat (2) pix(12'h000, 12'h000, 2'd0, 1'b1, 12'h123, "after_b2");

        // B3: deferred commit loads the 456 written during B1
        bnd(12'h000, 12'h000, 2'd0, 12'h123, 12'h456, 1'b1, 1'b0, 1'b1, 1'b1,
            1'b0, 3'd0, 12'h000, 1'b0, "b3");
        pix(12'h000, 12'h000, 2'd1, 1'b1, 12'h000, "reserved_ignored");
        pix(12'h000, 12'h000, 2'd0, 1'b1, 12'h456, "after_b3");

        // Blink mask on icon 0
        wr(3'd0, 12'hFFF, 12'h456, "wr_pal0_white");
        wr(3'd4, 12'h001, 12'h456, "wr_mask");
        cmt(12'h456, 1'b1, "commit_mask");
        pix(12'hF00, 12'h000, 2'd0, 1'b1, 12'hF00, "mask_not_active");
        bnd(12'hF00, 12'h000, 2'd0, 12'hF00, 12'hF00, 1'b1, 1'b0, 1'b1, 1'b0,
            1'b0, 3'd0, 12'h000, 1'b0, "b4");
        bnd(12'hF00, 12'h000, 2'd0, 12'hF00, 12'hF00, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b0, 3'd0, 12'h000, 1'b0, "b5");
        bnd(12'hF00, 12'h000, 2'd0, 12'hF00, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b1,
            1'b0, 3'd0, 12'h000, 1'b0, "b6");
        pix(12'hF00, 12'h00F, 2'd0, 1'b1, 12'h00F, "icon1_through_blink");
        pix(12'hF00, 12'h000, 2'd2, 1'b1, 12'h840, "hidden_world2");
        bnd(12'hF00, 12'h000, 2'd0, 12'hFFF, 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b1,
            1'b0, 3'd0, 12'h000, 1'b0, "b7");
        bnd(12'hF00, 12'h000, 2'd0, 12'hFFF, 12'hF00, 1'b0, 1'b0, 1'b1, 1'b0,
            1'b0, 3'd0, 12'h000, 1'b0, "b8");

        // Reset while a commit is pending discards it
        wr(3'd0, 12'h123, 12'hFFF, "wr_pal0_again");
        cmt(12'hFFF, 1'b0, "commit_before_reset");
        do_reset("reset_pending");
        pix(12'h000, 12'h000, 2'd0, 1'b1, 12'hFFF, "after_reset_pal0");
        bnd(12'h000, 12'h000, 2'd0, 12'hFFF, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b0, 3'd0, 12'h000, 1'b0, "b_after_reset");
        pix(12'h000, 12'h000, 2'd0, 1'b1, 12'hFFF, "final_pal0");

        repeat (4) @(negedge clk);
        total++;
        if (pix_q.size() != 0 || st_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending entries pix=%0d st=%0d want=0/0",
                     pix_q.size(), st_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
